registered_comparator: RTL

Parametrised, registered magnitude comparator for the Lab3 datapath. Compares a stream of valid-qualified input samples against a loadable reference register. Produces per-sample G/E/L flags one cycle later, persistence-filtered "stable" flags, and a saturating count of equal samples. It is the next generation of the 4-bit combinational Comparitor: generic width, signed/unsigned mode, and sequential filtering and counting.

---
 rtl/registered_comparator_pkg.sv | 20 ++
 rtl/registered_comparator_core.sv | 29 ++
 rtl/registered_comparator.sv | 112 +++++++++++
 3 files changed

// File: rtl/registered_comparator_pkg.sv
// Shared types for the registered comparator: sample relation encoding and
// the stable-relation filter state.
package ComparatorPkg;

   typedef enum logic [1:0] {
      REL_NONE,
      REL_LESS,
      REL_EQUAL,
      REL_GREATER
   } Relation_t;

   typedef enum logic {
      ST_UNKNOWN,
      ST_STABLE
   } StableState_t;

   // Run counter width; covers the legal PERSIST range 1..15.
   localparam int RunWidth = 4;

endpackage

// File: rtl/registered_comparator_core.sv
// Combinational magnitude compare of one sample against the reference,
// signed or unsigned depending on SIGNED.
module ComparatorCore
   import ComparatorPkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic [WIDTH-1:0] sampleValue,
   input  logic [WIDTH-1:0] referenceValue,
   output Relation_t        relation
);

   logic isLess;
   logic isGreater;

   always_comb begin
      if (SIGNED) begin
         isLess    = $signed(sampleValue) < $signed(referenceValue);
         isGreater = $signed(sampleValue) > $signed(referenceValue);
      end else begin
         isLess    = sampleValue < referenceValue;
         isGreater = sampleValue > referenceValue;
      end
   end

   assign relation = isGreater ? REL_GREATER : (isLess ? REL_LESS : REL_EQUAL);

endmodule

// File: rtl/registered_comparator.sv
// Registered comparator: reference register, 1-cycle raw G/E/L flags,
// persistence-filtered stable flags and a saturating equal-sample count.
module registered_comparator
   import ComparatorPkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SIGNED      = 0,
   parameter int PERSIST     = 3,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   LoadReference,
   input  logic [WIDTH-1:0]       ReferenceIn,
   input  logic                   InValid,
   input  logic [WIDTH-1:0]       ComparisonInput,
   input  logic                   ClearCount,
   output logic                   OutValid,
   output logic                   G,
   output logic                   E,
   output logic                   L,
   output logic                   StableG,
   output logic                   StableE,
   output logic                   StableL,
   output logic [COUNT_WIDTH-1:0] EqualCount
);

   localparam logic [RunWidth-1:0]    PersistRun = RunWidth'(PERSIST);
   localparam logic [COUNT_WIDTH-1:0] CountMax   = '1;

   logic [WIDTH-1:0]    referenceReg;
   Relation_t           relation;
   Relation_t           rawRel;
   Relation_t           lastRel, lastRelNext;
   logic [RunWidth-1:0] runCount, runNext;
   StableState_t        state, stateNext;
   Relation_t           stableRel, stableRelNext;
   logic                sampleInRun;

   ComparatorCore #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED != 0)
   ) core (
      .sampleValue    (ComparisonInput),
      .referenceValue (referenceReg),
      .relation       (relation)
   );

   // A sample coinciding with a reference load still reports, but the load wins the run.
   assign sampleInRun = InValid && !LoadReference;

   always_comb begin
      // NOTE: every always_comb output is given a default first so no path can infer a latch.
      runNext     = runCount;
      lastRelNext = lastRel;
      if (LoadReference) begin
         runNext     = '0;
         lastRelNext = REL_NONE;
      end else if (InValid) begin
         if (relation == lastRel) begin
            runNext = (runCount >= PersistRun) ? PersistRun : runCount + 1'b1;
         end else begin
            runNext     = RunWidth'(1);
            lastRelNext = relation;
         end
      end
   end

   always_comb begin
      stateNext     = state;
      stableRelNext = stableRel;
      if (sampleInRun && runNext == PersistRun) begin
         stateNext     = ST_STABLE;
         stableRelNext = relation;
      end
   end

   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (Reset) begin
         referenceReg <= '0;
         OutValid     <= 1'b0;
         rawRel       <= REL_NONE;
         runCount     <= '0;
         lastRel      <= REL_NONE;
         state        <= ST_UNKNOWN;
         stableRel    <= REL_NONE;
         EqualCount   <= '0;
      end else begin
         if (LoadReference) referenceReg <= ReferenceIn;
         OutValid  <= InValid;
         rawRel    <= InValid ? relation : REL_NONE;
         runCount  <= runNext;
         lastRel   <= lastRelNext;
         state     <= stateNext;
         stableRel <= stableRelNext;
         if (ClearCount) begin
            EqualCount <= '0;
         end else if (InValid && relation == REL_EQUAL && EqualCount != CountMax) begin
            EqualCount <= EqualCount + 1'b1;
         end
      end
   end

   assign G       = (rawRel == REL_GREATER);
   assign E       = (rawRel == REL_EQUAL);
   assign L       = (rawRel == REL_LESS);
   assign StableG = (stableRel == REL_GREATER);
   assign StableE = (stableRel == REL_EQUAL);
   assign StableL = (stableRel == REL_LESS);

endmodule
